// File: rtl/arduino_io_debounce_pkg.sv
// Shared definitions for the Arduino header input conditioning block.
// Default sizes match the 50 MHz build: a 10 us sample tick and 8 agreeing
// samples (about 80 us) before a new pin level is accepted.
package arduino_io_debounce_pkg;

  localparam int DEFAULT_WIDTH          = 16;
  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TICK_DIV       = 500;
  localparam int DEFAULT_DEBOUNCE_TICKS = 8;

  // Ceiling log2. Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Register width that can hold values 0..value-1. It is never narrower
  // than one bit, so a divide-by-one prescaler still gets a legal vector.
  function automatic int safe_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/arduino_io_debounce_bit.sv
// One conditioned pin: synchroniser, debounce counter, accepted level,
// rise/fall pulses and a sticky change flag.
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   tick          - shared sample strobe from the top-level prescaler
//   pin_in        - raw asynchronous pin
//   irq_clear     - one-cycle clear of change_flag
//   pin_state     - debounced level
//   rise, fall    - one-cycle pulses, aligned with the new pin_state
//   change_flag   - sticky "edge seen" flag
module arduino_io_debounce_bit
  import arduino_io_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter logic RESET_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pin_in,
  input  logic irq_clear,
  output logic pin_state,
  output logic rise,
  output logic fall,
  output logic change_flag
);

  localparam int CNT_W = safe_width(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   mismatch;
  logic                   accept;

  assign sync_q   = sync_r[SYNC_STAGES-1];
  assign mismatch = sync_q ^ pin_state;
  // The last of DEBOUNCE_TICKS consecutive differing samples.
  assign accept   = tick & mismatch & (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Any agreeing sample restarts qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (!mismatch || accept) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // rise/fall are registered together with pin_state so software sees the
  // pulse in the same cycle as the new level. sync_q is the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_state <= RESET_VALUE;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      if (accept) pin_state <= ~pin_state;
      rise <= accept & sync_q;
      fall <= accept & ~sync_q;
    end
  end

  // Set takes priority so an edge landing on a clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      change_flag <= 1'b0;
    end else if (rise || fall) begin
      change_flag <= 1'b1;
    end else if (irq_clear) begin
      change_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/arduino_io_debounce.sv
// Conditioning stage feeding the Arduino GPIO PIO in_port: synchronises and
// debounces the raw header pins and reports edges through pulses, sticky
// flags and a maskable interrupt.
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   pin_in        - raw header pins
//   irq_mask      - per-bit interrupt enable (1 = enabled)
//   irq_clear     - per-bit one-cycle clear of change_flags
//   pin_state     - debounced levels (to PIO in_port)
//   rise, fall    - per-bit one-cycle edge pulses
//   change_flags  - sticky per-bit edge flags
//   irq           - registered OR of change_flags & irq_mask
module arduino_io_debounce
  import arduino_io_debounce_pkg::*;
#(
  parameter int               WIDTH          = DEFAULT_WIDTH,
  parameter int               SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int               TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int               DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] pin_state,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] change_flags,
  output logic             irq
);

  localparam int PRE_W = safe_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // With TICK_DIV = 1 the counter sits at 0 == PRE_LAST and ticks every cycle.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    arduino_io_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_bit (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .pin_in      (pin_in[i]),
      .irq_clear   (irq_clear[i]),
      .pin_state   (pin_state[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .change_flag (change_flags[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(change_flags & irq_mask);
    end
  end

endmodule

// File: tb/tb_arduino_io_debounce.sv
module tb_arduino_io_debounce;

  localparam int W = 16;
  localparam int S = 2;
  localparam int T = 4;
  localparam int D = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [W-1:0] pin_in, irq_mask, irq_clear;
  logic [W-1:0] pin_state, rise, fall, change_flags;
  logic         irq;

  logic [W-1:0] pin_in2, irq_mask2, irq_clear2;
  logic [W-1:0] pin_state2, rise2, fall2, change_flags2;
  logic         irq2;

  arduino_io_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .TICK_DIV(T), .DEBOUNCE_TICKS(D), .RESET_VALUE('0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .irq_mask(irq_mask),
    .irq_clear(irq_clear), .pin_state(pin_state), .rise(rise), .fall(fall),
    .change_flags(change_flags), .irq(irq)
  );

  arduino_io_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .TICK_DIV(1), .DEBOUNCE_TICKS(D), .RESET_VALUE('0)
  ) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in2), .irq_mask(irq_mask2),
    .irq_clear(irq_clear2), .pin_state(pin_state2), .rise(rise2), .fall(fall2),
    .change_flags(change_flags2), .irq(irq2)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin history delayed by the synchroniser depth, a free-running edge
  // count since reset for tick placement, and per-bit run length of
  // consecutive tick samples that disagree with the accepted level.
  logic [W-1:0] hist_q[$];
  int unsigned  edge_cnt;
  int           run_len[W];
  logic [W-1:0] m_state, m_rise, m_fall, m_flags;
  logic         m_irq;

  task automatic model_reset();
    hist_q.delete();
    for (int k = 0; k < S; k++) hist_q.push_back('0);
    edge_cnt = 0;
    for (int i = 0; i < W; i++) run_len[i] = 0;
    m_state = '0; m_rise = '0; m_fall = '0; m_flags = '0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] sampled, n_rise, n_fall, n_flags;
    logic         n_irq;
    bit           is_tick;
    if (!reset_n) begin
      model_reset();
      return;
    end
    sampled = hist_q.pop_front();
    hist_q.push_back(pin_in);
    is_tick = ((edge_cnt % T) == T - 1);
    edge_cnt++;
    n_rise  = '0;
    n_fall  = '0;
    n_flags = (m_flags & ~irq_clear) | m_rise | m_fall;
    n_irq   = |(m_flags & irq_mask);
    if (is_tick) begin
      for (int i = 0; i < W; i++) begin
        if (sampled[i] == m_state[i]) begin
          run_len[i] = 0;
        end else begin
          run_len[i] = run_len[i] + 1;
          if (run_len[i] == D) begin
            m_state[i] = sampled[i];
            run_len[i] = 0;
            if (sampled[i]) n_rise[i] = 1'b1;
            else            n_fall[i] = 1'b1;
          end
        end
      end
    end
    m_rise  = n_rise;
    m_fall  = n_fall;
    m_flags = n_flags;
    m_irq   = n_irq;
  endtask

  task automatic compare_all();
    check("pin_state", pin_state, m_state);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("change_flags", change_flags, m_flags);
    check("irq", W'(irq), W'(m_irq));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later;
  // callers drive new inputs after this returns.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int pulses;
  bit seen;

  initial begin
    reset_n   = 1'b0;
    pin_in    = 16'hFFFF;
    irq_mask  = '0;
    irq_clear = '0;
    pin_in2   = '0;
    irq_mask2 = '0;
    irq_clear2 = '0;
    model_reset();

    // 1. reset held with all pins high, then release
    step(4);
    check("t1_rst_state", pin_state, 16'h0000);
    check("t1_rst_flags", change_flags, 16'h0000);
    reset_n = 1'b1;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (lat == 0 && pin_state == 16'hFFFF) lat = c;
      if (rise != 0) begin
        pulses++;
        check("t1_rise_val", rise, 16'hFFFF);
      end
    end
    check("t1_latency", W'(lat), W'(D * T));
    check("t1_rise_cycles", W'(pulses), 16'd1);
    check("t1_flags", change_flags, 16'hFFFF);

    // 2. glitch rejection on bit 0
    pin_in = '0;
    irq_clear = 16'hFFFF;
    step(1);
    irq_clear = '0;
    step(24);
    irq_clear = 16'hFFFF;
    step(1);
    irq_clear = '0;
    pin_in[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin step(1); if (rise[0]) seen = 1; end
    pin_in[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin step(1); if (rise[0]) seen = 1; end
    check("t2_state0", W'(pin_state[0]), 16'd0);
    check("t2_rise0", W'(seen), 16'd0);
    check("t2_flag0", W'(change_flags[0]), 16'd0);

    // 3. edge plus irq on bit 5, then again with the mask off
    irq_mask = 16'h0020;
    pin_in[5] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin step(1); if (rise[5]) pulses++; end
    check("t3_state5", W'(pin_state[5]), 16'd1);
    check("t3_rise5_cycles", W'(pulses), 16'd1);
    check("t3_flag5", W'(change_flags[5]), 16'd1);
    check("t3_irq", W'(irq), 16'd1);
    irq_mask = '0;
    irq_clear = 16'h0020;
    step(1);
    irq_clear = '0;
    pin_in[5] = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin step(1); if (irq) seen = 1; end
    check("t3_flag5_masked", W'(change_flags[5]), 16'd1);
    check("t3_irq_masked", W'(seen), 16'd0);

    // 4. clear colliding with fall keeps the flag; a lone clear drops it
    irq_mask = 16'h0020;
    pin_in[5] = 1'b1;
    step(20);
    irq_clear = 16'h0020;
    step(1);
    irq_clear = '0;
    step(2);
    pin_in[5] = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step(1);
      if (m_fall[5]) seen = 1;
    end
    check("t4_fall_seen", W'(seen), 16'd1);
    irq_clear = 16'h0020;
    step(1);
    irq_clear = '0;
    check("t4_flag_kept", W'(change_flags[5]), 16'd1);
    step(3);
    irq_clear = 16'h0020;
    step(1);
    irq_clear = '0;
    check("t4_flag_cleared", W'(change_flags[5]), 16'd0);
    step(1);
    check("t4_irq_cleared", W'(irq), 16'd0);

    // 5. reset mid-count on bit 3
    pin_in[3] = 1'b1;
    for (int c = 0; c < 20 && run_len[3] < 2; c++) step(1);
    check("t5_partial", W'(run_len[3]), 16'd2);
    reset_n = 1'b0;
    step(2);
    check("t5_rst_state", pin_state, 16'h0000);
    reset_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step(1);
      if (pin_state[3]) lat = c;
    end
    check("t5_latency", W'(lat), W'(D * T));

    // 6. divide-by-one build: step latency is exactly S + D cycles
    step(10);
    pin_in2[15] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step(1);
      if (pin_state2[15]) begin
        lat = c;
        check("t6_rise15", rise2, 16'h8000);
      end
    end
    check("t6_rise_latency", W'(lat), W'(S + D));
    step(1);
    check("t6_flag15", change_flags2, 16'h8000);
    pin_in2[15] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step(1);
      if (!pin_state2[15]) lat = c;
    end
    check("t6_fall_latency", W'(lat), W'(S + D));
    pin_in2[14] = 1'b1;
    step(2);
    pin_in2[14] = 1'b0;
    step(10);
    check("t6_glitch14", W'(pin_state2[14]), 16'd0);

    // Randomised traffic against the model, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) pin_in = pin_in ^ W'($urandom & $urandom & $urandom);
      irq_clear = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 63) == 0) irq_mask = W'($urandom);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
